run_sequencer: RTL and testbench
================================

RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 Parameter AW, default 8: data-memory address width.
REQ-002 Parameter LOAD_LEN, default 64: bytes loaded into data memory at addresses 0..LOAD_LEN-1; range 0..2^AW.
REQ-003 Parameter RES_BASE, default 64: first result address read back after the run.
REQ-004 Parameter RES_LEN, default 4: result bytes streamed out; range 1..2^AW.
REQ-005 Parameter TMO, default 4096: maximum RUN cycles before abort; TMO ≥ 1.
REQ-006 clk  in  1  rising-edge clock; the only clock.
REQ-007 reset  in  1  synchronous, active-low reset; 0 sampled at a clk edge resets the block.
REQ-008 start  in  1  request to begin a load/run/drain sequence.
REQ-009 in_valid  in  1; in_data  in  8; in_ready  out  1  byte-load stream, valid/ready handshake.
REQ-010 mem_wr_en  out  1; mem_addr  out  AW; mem_wr_data  out  8; mem_rd_data  in  8  data-memory port with asynchronous read.
REQ-011 core_req  out  1  single-cycle start pulse to the processor core.
REQ-012 core_done  in  1  core completion level.
REQ-013 out_valid  out  1; out_data  out  8; out_ready  in  1  result stream, valid/ready handshake.
REQ-014 busy  out  1  high in every state except IDLE and FIN.
REQ-015 timeout  out  1  sticky abort flag.

Function
REQ-016 The block SHALL implement the states IDLE, LOAD, KICK, RUN, DRAIN and FIN with registered state.
REQ-017 IDLE/FIN: start=1 SHALL go to LOAD (or to KICK if LOAD_LEN=0), clear the counters and clear timeout; start is ignored in all other states.
REQ-018 LOAD: in_ready=1; on in_valid&in_ready, mem_wr_en SHALL be 1 in the same cycle, with mem_addr=load_cnt and mem_wr_data=in_data, and load_cnt SHALL increment.
REQ-019 LOAD SHALL exit to KICK on the handshake with load_cnt=LOAD_LEN-1; without a handshake, state and counter SHALL hold.
REQ-020 in_ready and mem_wr_en SHALL be 0 outside LOAD.
REQ-021 KICK SHALL last exactly one cycle, with core_req=1, and then go to RUN; core_req SHALL be 0 in every other cycle.
REQ-022 RUN: cyc_cnt SHALL start at 0 and increment every cycle; core_done=1 SHALL go to DRAIN.
REQ-023 RUN: if cyc_cnt=TMO-1 and core_done=0, the block SHALL go to FIN, set timeout=1 and skip DRAIN.
REQ-024 If core_done=1 and cyc_cnt=TMO-1 in the same cycle, done SHALL win: go to DRAIN with timeout=0.
REQ-025 core_done SHALL be ignored outside RUN.
REQ-026 DRAIN: mem_addr = (RES_BASE + rd_cnt) mod 2^AW, wrapping silently.
REQ-027 DRAIN: out_data SHALL register mem_rd_data, and out_valid SHALL rise one cycle after the address is presented.
REQ-028 While out_valid=1 and out_ready=0, out_valid and out_data SHALL hold stable.
REQ-029 On out_valid&out_ready, rd_cnt SHALL increment and out_valid SHALL drop for at least one cycle (peak rate 1 byte per 2 cycles).
REQ-030 After the RES_LEN-th handshake, the block SHALL go to FIN with out_valid=0.
REQ-031 mem_addr SHALL be 0 in IDLE, KICK, RUN and FIN.
REQ-032 FIN SHALL hold timeout until the next start.

Reset
REQ-033 While reset=0 at a clk edge, the block SHALL go to IDLE on that edge from any state, including mid-LOAD and mid-DRAIN.
REQ-034 After that reset edge: all counters=0, in_ready=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, core_req=0, out_valid=0, out_data=0, busy=0, timeout=0.
REQ-035 A byte offered in the same cycle as reset=0 SHALL NOT be written to memory.

Verification
REQ-036 LOAD_LEN=4, RES_BASE=4, RES_LEN=2; stream 11,22,33,44 with gaps; model core writes 0xAA,0xBB at 4,5, done after 10 cycles -> writes at addresses 0..3, one core_req pulse, out_data 0xAA then 0xBB, FIN with busy=0 and timeout=0.
REQ-037 TMO=16; core_done never asserted -> FIN exactly 16 cycles after KICK, timeout=1, no out_valid; the next start clears timeout.
REQ-038 out_ready held 0 for 5 cycles while out_valid=1 -> out_data stable for all 5 cycles and each byte delivered exactly once.
REQ-039 RES_BASE=254, RES_LEN=4, AW=8 -> DRAIN addresses 254, 255, 0, 1.
REQ-040 reset=0 asserted after 2 of 4 LOAD bytes, then start reissued -> full reload beginning at address 0, no stray core_req.
REQ-041 start pulsed during RUN, and core_done=1 during LOAD -> both ignored; the sequence is unchanged.

Source files
------------

// File: rtl/run_sequencer.sv
// run_sequencer
//   Sequences one job for a processor core: stream LOAD_LEN bytes into data
//   memory, pulse the core, wait for completion (or abort after TMO cycles),
//   then stream RES_LEN result bytes back out of memory starting at RES_BASE.
//
// Ports
//   clk_i          rising-edge clock
//   reset_i        synchronous active-low reset
//   start_i        begin a load/run/drain sequence (honoured in IDLE/FIN only)
//   in_valid_i     byte-load stream valid
//   in_data_i      byte-load stream data
//   in_ready_o     byte-load stream ready (high throughout LOAD)
//   mem_wr_en_o    data-memory write enable
//   mem_addr_o     data-memory address (load counter in LOAD, result pointer in DRAIN, else 0)
//   mem_wr_data_o  data-memory write data
//   mem_rd_data_i  data-memory asynchronous read data
//   core_req_o     one-cycle start pulse to the core
//   core_done_i    core completion level (sampled in RUN only)
//   out_valid_o    result stream valid
//   out_data_o     result stream data
//   out_ready_i    result stream ready
//   busy_o         high in every state except IDLE and FIN
//   timeout_o      sticky abort flag, cleared by the next accepted start
//   state_o        current FSM state, for debug and checkers
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. A source never withdraws valid or changes data while waiting
// for ready; ready may be asserted independently of valid.
module run_sequencer #(
    parameter int AW       = 8,
    parameter int LOAD_LEN = 64,
    parameter int RES_BASE = 64,
    parameter int RES_LEN  = 4,
    parameter int TMO      = 4096
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          start_i,
    input  logic          in_valid_i,
    input  logic [7:0]    in_data_i,
    output logic          in_ready_o,
    output logic          mem_wr_en_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [7:0]    mem_wr_data_o,
    input  logic [7:0]    mem_rd_data_i,
    output logic          core_req_o,
    input  logic          core_done_i,
    output logic          out_valid_o,
    output logic [7:0]    out_data_o,
    input  logic          out_ready_i,
    output logic          busy_o,
    output logic          timeout_o,
    output logic [2:0]    state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_KICK  = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;

    localparam logic [AW-1:0] LOAD_LAST  = AW'(LOAD_LEN - 1);
    localparam logic [AW-1:0] RES_LAST   = AW'(RES_LEN - 1);
    localparam logic [AW-1:0] RES_BASE_A = AW'(RES_BASE);
    localparam logic [CW-1:0] TMO_LAST   = CW'(TMO - 1);

    state_t        state_q;
    logic [AW-1:0] load_cnt_q;
    logic [AW-1:0] rd_cnt_q;
    logic [CW-1:0] cyc_cnt_q;
    logic          out_valid_q;
    logic [7:0]    out_data_q;
    logic          timeout_q;

    // A byte offered in a reset cycle must not reach memory, so the write
    // strobe is qualified by reset as well as by the registered state.
    logic load_hs;
    assign load_hs = (state_q == S_LOAD) && in_valid_i && reset_i;

    assign in_ready_o    = (state_q == S_LOAD) && reset_i;
    assign mem_wr_en_o   = load_hs;
    assign mem_wr_data_o = load_hs ? in_data_i : 8'h00;
    assign core_req_o    = (state_q == S_KICK);
    assign busy_o        = (state_q != S_IDLE) && (state_q != S_FIN);
    assign out_valid_o   = out_valid_q;
    assign out_data_o    = out_data_q;
    assign timeout_o     = timeout_q;
    assign state_o       = state_q;

    // Result pointer wraps modulo 2^AW through the natural AW-bit add.
    always_comb begin
        mem_addr_o = '0;
        case (state_q)
            S_LOAD:  mem_addr_o = load_cnt_q;
            S_DRAIN: mem_addr_o = RES_BASE_A + rd_cnt_q;
            default: mem_addr_o = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q     <= S_IDLE;
            load_cnt_q  <= '0;
            rd_cnt_q    <= '0;
            cyc_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            timeout_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_FIN: begin
                    if (start_i) begin
                        load_cnt_q <= '0;
                        rd_cnt_q   <= '0;
                        cyc_cnt_q  <= '0;
                        timeout_q  <= 1'b0;
                        state_q    <= (LOAD_LEN == 0) ? S_KICK : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_valid_i) begin
                        load_cnt_q <= load_cnt_q + AW'(1);
                        if (load_cnt_q == LOAD_LAST) begin
                            state_q <= S_KICK;
                        end
                    end
                end
                S_KICK: begin
                    cyc_cnt_q <= '0;
                    state_q   <= S_RUN;
                end
                S_RUN: begin
                    cyc_cnt_q <= cyc_cnt_q + CW'(1);
                    // Completion is checked first so a done on the final
                    // allowed cycle still drains instead of aborting.
                    if (core_done_i) begin
                        rd_cnt_q    <= '0;
                        out_valid_q <= 1'b0;
                        state_q     <= S_DRAIN;
                    end else if (cyc_cnt_q == TMO_LAST) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_FIN;
                    end
                end
                S_DRAIN: begin
                    // Two-phase loop: present address (valid low), capture
                    // the read into out_data, then hold until accepted.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= mem_rd_data_i;
                    end else if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        rd_cnt_q    <= rd_cnt_q + AW'(1);
                        if (rd_cnt_q == RES_LAST) begin
                            state_q <= S_FIN;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: a data memory with asynchronous read, a simple
// core model that writes RES_LEN result bytes and raises done, a random
// out_ready driver, and a negedge monitor scoring writes and result bytes
// against queues filled by the stimulus tasks.
module tb_run_sequencer;

    localparam int AW       = 8;
    localparam int LOAD_LEN = 4;
    localparam int RES_BASE = 254;
    localparam int RES_LEN  = 4;
    localparam int TMO      = 16;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wr_data;
    logic [7:0]    mem_rd_data;
    logic          core_req;
    logic          core_done;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_ready;
    logic          busy;
    logic          timeout;
    logic [2:0]    state;

    run_sequencer #(
        .AW(AW), .LOAD_LEN(LOAD_LEN), .RES_BASE(RES_BASE),
        .RES_LEN(RES_LEN), .TMO(TMO)
    ) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
        .mem_wr_en_o(mem_wr_en), .mem_addr_o(mem_addr),
        .mem_wr_data_o(mem_wr_data), .mem_rd_data_i(mem_rd_data),
        .core_req_o(core_req), .core_done_i(core_done),
        .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready),
        .busy_o(busy), .timeout_o(timeout), .state_o(state)
    );

    // data memory shared by the sequencer and the core model
    logic [7:0] mem [256];
    logic       core_we;
    logic [7:0] core_vals [RES_LEN];

    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
        if (core_we) begin
            for (int i = 0; i < RES_LEN; i++) mem[(RES_BASE + i) % 256] <= core_vals[i];
        end
    end
    assign mem_rd_data = mem[mem_addr];

    // scoreboard
    logic [15:0] exp_wr_q[$];   // {addr, data} expected on the write port
    logic [7:0]  exp_q[$];      // expected result bytes in order
    int errs   = 0;
    int checks = 0;
    int req_cnt = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // out_ready driver: random, or a fixed 5-cycle stall per byte
    bit hold_mode = 1'b0;
    int stall_n   = 0;
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (hold_mode) begin
                if (out_valid) begin
                    if (stall_n == 5) begin
                        out_ready = 1'b1;
                        stall_n   = 0;
                    end else begin
                        out_ready = 1'b0;
                        stall_n++;
                    end
                end else begin
                    out_ready = 1'b0;
                    stall_n   = 0;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // monitor
    logic       prev_stall = 1'b0;
    logic       prev_hs    = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    always @(negedge clk) begin
        if (core_req) req_cnt <= req_cnt + 1;
        if (mem_wr_en) begin
            if (exp_wr_q.size() == 0) begin
                chk1("unexpected_wr", mem_wr_en, 1'b0);
            end else begin
                chk8("wr_addr", mem_addr, exp_wr_q[0][15:8]);
                chk8("wr_data", mem_wr_data, exp_wr_q[0][7:0]);
                void'(exp_wr_q.pop_front());
            end
        end
        if (reset === 1'b1) begin
            if (prev_stall) begin
                chk1("hold_valid", out_valid, 1'b1);
                chk8("hold_data", out_data, prev_data);
            end
            if (prev_hs) chk1("valid_drop", out_valid, 1'b0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk1("unexpected_out", out_valid, 1'b0);
                else chk8("out_data", out_data, exp_q.pop_front());
            end
        end
        prev_stall <= out_valid && !out_ready && (reset === 1'b1);
        prev_hs    <= out_valid && out_ready && (reset === 1'b1);
        prev_data  <= out_data;
    end

    // driver tasks
    task automatic do_reset(input bit with_byte);
        @(posedge clk); #1;
        reset = 1'b0;
        if (with_byte) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
        end
        @(negedge clk);
        chk1("no_wr_in_reset", mem_wr_en, 1'b0);
        @(posedge clk); #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_mem_wr_en", mem_wr_en, 1'b0);
        chk8("rst_mem_addr", mem_addr, 8'h00);
        chk8("rst_mem_wr_data", mem_wr_data, 8'h00);
        chk1("rst_core_req", core_req, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk8("rst_out_data", out_data, 8'h00);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_timeout", timeout, 1'b0);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    // k < 0: the core never finishes; otherwise done rises on RUN cycle k
    task automatic run_seq(input int k, input bit done_in_load,
                           input bit start_in_run, input bit hold);
        int n;
        int req0;
        hold_mode = hold;
        req0 = req_cnt;
        pulse_start();
        @(negedge clk);
        chk1("timeout_clear", timeout, 1'b0);
        chk1("busy_load", busy, 1'b1);
        @(posedge clk); #1;
        core_done = done_in_load;
        for (int i = 0; i < LOAD_LEN; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            in_data  = 8'($urandom);
            in_valid = 1'b1;
            exp_wr_q.push_back({8'(i), in_data});
            @(negedge clk);
            chk1("in_ready", in_ready, 1'b1);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        core_done = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (core_req) break;
            n++;
        end
        chk_int("kick_latency", n, 0);
        @(posedge clk); #1;
        if (k < 0) begin
            n = 0;
            while (n < 100) begin
                @(negedge clk);
                if (!busy) break;
                chk8("run_addr", mem_addr, 8'h00);
                n++;
            end
            chk_int("run_cycles", n, TMO);
            chk1("timeout_set", timeout, 1'b1);
            repeat (3) @(negedge clk);
            chk1("timeout_hold", timeout, 1'b1);
            chk1("fin_busy", busy, 1'b0);
        end else begin
            for (int j = 0; j < k; j++) begin
                if (start_in_run && j == 0) start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                if (start_in_run && j == 0) begin
                    @(negedge clk);
                    chk1("start_ignored", in_ready, 1'b0);
                    chk1("busy_run", busy, 1'b1);
                end
            end
            for (int i = 0; i < RES_LEN; i++) begin
                core_vals[i] = 8'($urandom);
                exp_q.push_back(core_vals[i]);
            end
            core_we   = 1'b1;
            core_done = 1'b1;
            @(posedge clk); #1;
            core_we = 1'b0;
            n = 0;
            while (n < 400) begin
                @(negedge clk);
                if (!busy) break;
                n++;
            end
            if (n == 400) chk1("drain_wait", busy, 1'b0);
            @(posedge clk); #1;
            core_done = 1'b0;
            chk1("fin_timeout", timeout, 1'b0);
        end
        @(negedge clk);
        chk1("fin_out_valid", out_valid, 1'b0);
        chk_int("out_left", exp_q.size(), 0);
        chk_int("writes_left", exp_wr_q.size(), 0);
        chk_int("core_req_pulses", req_cnt - req0, 1);
        exp_q.delete();
    endtask

    task automatic abort_load();
        int req0;
        req0 = req_cnt;
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            in_data  = 8'($urandom);
            in_valid = 1'b1;
            exp_wr_q.push_back({8'(i), in_data});
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        do_reset(1'b1);
        chk_int("abort_writes", exp_wr_q.size(), 0);
        exp_wr_q.delete();
        repeat (3) @(negedge clk);
        chk_int("abort_core_req", req_cnt - req0, 0);
    endtask

    // main sequence
    initial begin
        int k;
        reset     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        core_done = 1'b0;
        core_we   = 1'b0;
        for (int i = 0; i < RES_LEN; i++) core_vals[i] = 8'h00;
        repeat (2) @(posedge clk);
        do_reset(1'b0);

        run_seq(10, 1'b0, 1'b0, 1'b0);
        run_seq(TMO - 1, 1'b0, 1'b0, 1'b1);
        run_seq(-1, 1'b0, 1'b0, 1'b0);
        run_seq(5, 1'b1, 1'b1, 1'b0);
        abort_load();
        run_seq(3, 1'b0, 1'b0, 1'b0);
        for (int s = 0; s < 6; s++) begin
            k = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, TMO - 1));
            run_seq(k, 1'($urandom_range(0, 1)),
                    (k >= 1) && ($urandom_range(0, 1) == 1), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errs);
        $fatal(1);
    end

endmodule
